uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter byte interface among N_REQ requesters, such as a status reporter, an echo path fed by the UART receiver, and a debug dumper.
Each grant is held for a whole message, from the first byte through the byte flagged last, so messages never interleave on the serial line.
A stall timeout reclaims the transmitter from a requester that stops supplying bytes mid-message.
Sits between the requesters and the UART transmitter. Same i_clk domain as the transmitter.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter byte port among requesters.
// A grant lasts a whole message; a stall timeout reclaims an abandoned grant.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_ready,
  output logic               o_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_d;
  logic [IW-1:0] g, g_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          tmo, tmo_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  int            idx;
  logic          sel_valid;
  logic          sel_last;
  logic          xfer;
  logic [IW-1:0] g_inc;

  // First requesting index scanning circularly from the pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx  = (int'(ptr) + i) % N_REQ;
      cand = IW'(idx);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_valid = i_req_valid[g];
  assign sel_last  = i_req_last[g];
  assign xfer      = (state == LOCKED) && sel_valid && i_tx_ready;
  assign g_inc     = (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);

  always_comb begin
    o_grant     = '0;
    o_req_ready = '0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    if (state == LOCKED) begin
      o_grant[g]     = 1'b1;
      o_req_ready[g] = i_tx_ready;
      o_tx_valid     = sel_valid;
      o_tx_data      = i_req_data[8*g +: 8];
    end
  end

  always_comb begin
    state_d = state;
    g_d     = g;
    ptr_d   = ptr;
    cnt_d   = cnt;
    tmo_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          g_d     = pick;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_d = '0;
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = g_inc;
          end
        end else if (!sel_valid) begin
          // Back-pressure holds the count; only a silent owner ages
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            ptr_d   = g_inc;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      cnt   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_d;
      g     <= g_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      tmo   <= tmo_d;
    end
  end

  assign o_timeout = tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, scoreboard of
// transferred bytes, and hand-written stall/timeout/reset sequences.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic           timeout;

  uart_tx_arbiter #(
    .N_REQ         (N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_grant    (grant),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_timeout  (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int seq   = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    int           exp;
  } row_t;

  exp_t sbq[$];
  exp_t me;
  row_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      xfers++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra got=%0h want=none", tx_data);
      end else begin
        me = sbq.pop_front();
        chk("sb_grant", 32'(grant), 32'(1) << me.idx);
        chk("sb_data", 32'(tx_data), 32'(me.data));
      end
    end
  end

  task automatic arb_one(input logic [N-1:0] mask, input int exp,
                         input string nm);
    logic [7:0] d;
    tick();
    for (int k = 0; k < N; k++) begin
      d = {4'(k), 4'(seq)};
      req_data[8*k +: 8] = d;
      if (k == exp) sbq.push_back('{k, d});
    end
    seq++;
    req_valid = mask;
    req_last  = mask;
    tx_ready  = 1'b1;
    @(negedge clk);
    chk({nm, "_idle"}, 32'(grant), 0);
    tick();
    @(negedge clk);
    chk({nm, "_grant"}, 32'(grant), 32'(1) << exp);
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk({nm, "_rel"}, 32'(grant), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] pat [10];
    int tocnt;
    int lost;

    tbl[0] = '{4'b0101, 2};
    tbl[1] = '{4'b0011, 0};
    tbl[2] = '{4'b1000, 3};
    tbl[3] = '{4'b1110, 1};
    tbl[4] = '{4'b0010, 1};
    tbl[5] = '{4'b1111, 2};
    tbl[6] = '{4'b0001, 0};

    rst       = 1'b1;
    req_valid = '1;
    req_last  = '0;
    req_data  = '1;
    tx_ready  = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_tmo", 32'(timeout), 0);

    // single requester, three-byte message
    tick();
    rst       = 1'b0;
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[7:0] = 8'h41;
    sbq.push_back('{0, 8'h41});
    sbq.push_back('{0, 8'h42});
    sbq.push_back('{0, 8'h43});
    @(negedge clk);
    chk("t1_lat", 32'(grant), 0);
    tick();
    @(negedge clk);
    chk("t1_grant", 32'(grant), 1);
    tick();
    req_data[7:0] = 8'h42;
    @(negedge clk);
    tick();
    req_data[7:0] = 8'h43;
    req_last      = 4'b0001;
    @(negedge clk);
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t1_rel", 32'(grant), 0);
    chk("t1_xfers", 32'(xfers), 3);

    for (int i = 0; i < 7; i++)
      arb_one(tbl[i].mask, tbl[i].exp, $sformatf("tbl%0d", i));

    // all four requesting continuously after reset
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = '1;
    req_last  = '1;
    for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'(8'hA0 + k);
    sbq.push_back('{0, 8'hA0});
    sbq.push_back('{1, 8'hA1});
    sbq.push_back('{2, 8'hA2});
    sbq.push_back('{3, 8'hA3});
    sbq.push_back('{0, 8'hA0});
    pat = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk($sformatf("t2_rr%0d", i), 32'(grant), 32'(pat[i]));
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t2_rel", 32'(grant), 0);

    // requester 2 with transmitter back-pressure
    tick();
    req_valid = 4'b0100;
    req_data[23:16] = 8'hC1;
    tx_ready  = 1'b1;
    sbq.push_back('{2, 8'hC1});
    sbq.push_back('{2, 8'hC2});
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t3_rdy1", 32'(req_ready), 32'h4);
    chk("t3_d1", 32'(tx_data), 32'hC1);
    tick();
    req_data[23:16] = 8'hC2;
    req_last = 4'b0100;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("t3_rdy2", 32'(req_ready), 0);
    chk("t3_v2", 32'(tx_valid), 1);
    chk("t3_d2", 32'(tx_data), 32'hC2);
    tick();
    @(negedge clk);
    chk("t3_rdy3", 32'(req_ready), 0);
    chk("t3_d3", 32'(tx_data), 32'hC2);
    tick();
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t3_rdy4", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t3_rel", 32'(grant), 0);

    // requester 1 abandons its message
    tick();
    req_valid = 4'b0010;
    req_data[15:8] = 8'hD1;
    sbq.push_back('{1, 8'hD1});
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk($sformatf("t4_g%0d", i), 32'(grant), (i < 8) ? 32'h2 : 0);
      chk($sformatf("t4_to%0d", i), 32'(timeout), (i == 8) ? 1 : 0);
    end
    arb_one(4'b0110, 2, "t4_ptr");

    // long back-pressure must not time out
    tick();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    req_data[31:24] = 8'hE3;
    tx_ready  = 1'b0;
    sbq.push_back('{3, 8'hE3});
    @(negedge clk);
    tick();
    tocnt = 0;
    lost  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (timeout) tocnt++;
      if (grant != 4'b1000) lost++;
      tick();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t5_tmo", 32'(tocnt), 0);
    chk("t5_lost", 32'(lost), 0);
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t5_rel", 32'(grant), 0);
    chk("t5_tmo2", 32'(timeout), 0);

    // reset mid-message, then pointer back at 0
    arb_one(4'b0010, 1, "t6_pre");
    tick();
    req_valid = 4'b0100;
    req_data[23:16] = 8'hF0;
    sbq.push_back('{2, 8'hF0});
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    req_data[23:16] = 8'hF1;
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst       = 1'b0;
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    req_data[7:0]   = 8'h90;
    req_data[31:24] = 8'h93;
    sbq.push_back('{0, 8'h90});
    @(negedge clk);
    chk("t6_grant", 32'(grant), 0);
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_txv", 32'(tx_valid), 0);
    chk("t6_txd", 32'(tx_data), 0);
    chk("t6_tmo", 32'(timeout), 0);
    tick();
    @(negedge clk);
    chk("t6_win", 32'(grant), 1);
    tick();
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("t6_rel", 32'(grant), 0);

    chk("sb_left", 32'(sbq.size()), 0);
    chk("xfer_count", 32'(xfers), 23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
